// File: rtl/hall_commutator_if.sv
// Signal bundle between the six-step commutation front end and whatever drives/observes it.
interface hall_commutator_if;
    logic        hallGrn;
    logic        hallYlw;
    logic        hallBlu;
    logic        PWM_synch;
    logic        brake_n;
    logic [11:0] drv_mag;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic [10:0] duty;
    logic        comm_step;
    logic        hall_fault;
    logic        stall;

    modport master (
        output hallGrn, hallYlw, hallBlu, PWM_synch, brake_n, drv_mag,
        input  selGrn, selYlw, selBlu, duty, comm_step, hall_fault, stall
    );

    modport slave (
        input  hallGrn, hallYlw, hallBlu, PWM_synch, brake_n, drv_mag,
        output selGrn, selYlw, selBlu, duty, comm_step, hall_fault, stall
    );
endinterface

// File: rtl/hall_commutator.sv
// Six-step BLDC commutation front end: hall sync/debounce on PWM_synch, phase select and duty.
// Optional stall detector enabled by defining STALL_DET_EN.
module hall_commutator #(
    parameter int unsigned DEB_CNT    = 2,
    parameter logic [10:0] MIN_DUTY   = 11'h400,
    parameter logic [10:0] BRAKE_DUTY = 11'h600
`ifdef STALL_DET_EN
    , parameter logic [15:0] STALL_PERIODS = 16'd4096
`endif
) (
    input logic              clk,
    input logic              rst,
    hall_commutator_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_BRAKE, S_FAULT} state_t;

    localparam logic [2:0] DEB = 3'(DEB_CNT);

    state_t      r_state, w_state_next;
    logic [2:0]  r_cand, w_cand_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic [2:0]  r_acc, w_acc_next;
    logic        r_seen;
    logic        w_accept, w_legal, w_comm;
    logic [5:0]  r_sel, w_sel;
    logic [10:0] r_duty, w_duty;
    logic        r_comm, r_fault;
    logic [2:0]  w_hall_raw, w_hall_sync;
    logic [11:0] w_sum;
    logic [10:0] w_run_duty;
    logic        w_unused_drv;

    assign w_hall_raw   = {bus.hallGrn, bus.hallYlw, bus.hallBlu};
    assign w_unused_drv = ^bus.drv_mag[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic r_s1, r_s2;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_hall_raw[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_hall_sync[gi] = r_s2;
        end
    endgenerate

    function automatic logic [5:0] f_table(input logic [2:0] h);
        case (h)
            3'b101:  f_table = 6'b10_01_00;
            3'b100:  f_table = 6'b10_00_01;
            3'b110:  f_table = 6'b00_10_01;
            3'b010:  f_table = 6'b01_10_00;
            3'b011:  f_table = 6'b01_00_10;
            3'b001:  f_table = 6'b00_01_10;
            default: f_table = 6'b00_00_00;
        endcase
    endfunction

    // Acceptance fires only on the sample where the run of identical codes first hits DEB.
    always_comb begin
        w_cand_next = r_cand;
        w_cnt_next  = r_cnt;
        w_accept    = 1'b0;
        if (bus.PWM_synch) begin
            if (w_hall_sync == r_cand) begin
                if (r_cnt != DEB) begin
                    w_cnt_next = 3'(r_cnt + 3'd1);
                    w_accept   = (3'(r_cnt + 3'd1) == DEB);
                end
            end else begin
                w_cand_next = w_hall_sync;
                w_cnt_next  = 3'd1;
                w_accept    = (DEB == 3'd1);
            end
        end
    end

    assign w_acc_next = w_accept ? w_cand_next : r_acc;
    assign w_legal    = (w_acc_next != 3'b000) && (w_acc_next != 3'b111);
    assign w_comm     = w_accept && (!r_seen || (w_cand_next != r_acc));
    assign w_sum      = {1'b0, MIN_DUTY} + {2'b00, bus.drv_mag[11:2]};
    assign w_run_duty = w_sum[11] ? 11'h7FF : w_sum[10:0];

    // Illegal code outranks brake, brake outranks the commutation table.
    always_comb begin
        w_state_next = r_state;
        w_sel        = 6'b00_00_00;
        w_duty       = 11'h000;
        if (bus.PWM_synch) begin
            case (r_state)
                S_INIT, S_FAULT: begin
                    if (w_accept)
                        w_state_next = !w_legal ? S_FAULT : (!bus.brake_n ? S_BRAKE : S_RUN);
                end
                S_RUN: begin
                    if (w_accept && !w_legal) w_state_next = S_FAULT;
                    else if (!bus.brake_n)    w_state_next = S_BRAKE;
                end
                S_BRAKE: begin
                    if (w_accept && !w_legal)       w_state_next = S_FAULT;
                    else if (bus.brake_n && w_legal) w_state_next = S_RUN;
                end
                default: w_state_next = S_INIT;
            endcase
        end
        case (w_state_next)
            S_RUN: begin
                w_sel  = f_table(w_acc_next);
                w_duty = w_run_duty;
            end
            S_BRAKE: begin
                w_sel  = 6'b11_11_11;
                w_duty = BRAKE_DUTY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cand  <= 3'b000;
            r_cnt   <= 3'd0;
            r_acc   <= 3'b000;
            r_seen  <= 1'b0;
            r_sel   <= 6'b00_00_00;
            r_duty  <= 11'h000;
            r_comm  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
            r_acc   <= w_acc_next;
            r_seen  <= r_seen | w_accept;
            r_sel   <= w_sel;
            r_duty  <= w_duty;
            r_comm  <= w_comm;
            r_fault <= (w_state_next == S_FAULT);
        end
    end

`ifdef STALL_DET_EN
    logic [15:0] r_stall_cnt, w_stall_cnt_next;
    logic        r_stall;

    always_comb begin
        w_stall_cnt_next = r_stall_cnt;
        if (w_comm || (w_state_next != S_RUN))
            w_stall_cnt_next = 16'd0;
        else if (bus.PWM_synch && (r_state == S_RUN) && (r_stall_cnt != STALL_PERIODS))
            w_stall_cnt_next = r_stall_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_stall     <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_next;
            if (w_comm || ((w_state_next == S_BRAKE) && (r_state != S_BRAKE)))
                r_stall <= 1'b0;
            else if (w_stall_cnt_next == STALL_PERIODS)
                r_stall <= 1'b1;
        end
    end

    assign bus.stall = r_stall;
`else
    assign bus.stall = 1'b0;
`endif

    assign bus.selGrn     = r_sel[5:4];
    assign bus.selYlw     = r_sel[3:2];
    assign bus.selBlu     = r_sel[1:0];
    assign bus.duty       = r_duty;
    assign bus.comm_step  = r_comm;
    assign bus.hall_fault = r_fault;
endmodule
